// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding memory read at a time, pushes each
// returned word with its pc to the instruction queue, and handles misbranch flushes.
module fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  out_pc_ena,
  output logic [ADDR_WIDTH-1:0] out_last_pc,
  output logic [INST_WIDTH-1:0] out_last_inst,
  input  logic [ADDR_WIDTH-1:0] in_next_pc,
  input  logic                  in_clear_all,
  output logic                  out_mem_req,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ready,
  input  logic                  in_mem_valid,
  input  logic [INST_WIDTH-1:0] in_mem_data,
  output logic                  out_inst_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_inst_pc,
  input  logic                  in_queue_full,
  output logic [2:0]            dbg_state
);

  // Handshakes: a memory request transfers on the cycle out_mem_req && in_mem_ready,
  // and req/addr stay stable until then; in_mem_valid and out_inst_valid are
  // single-cycle strobes with no back-pressure other than in_queue_full.
  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT     = 3'd1,
    S_DISPATCH = 3'd2,
    S_NEXT     = 3'd3,
    S_DROP     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_q, fetch_d;
  logic [INST_WIDTH-1:0] buf_q, buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      fetch_q <= BOOT_ADDR;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_d        = fetch_q;
    buf_d          = buf_q;
    out_mem_req    = 1'b0;
    out_pc_ena     = 1'b0;
    out_inst_valid = 1'b0;
    out_last_pc    = '0;
    out_last_inst  = '0;
    out_inst_pc    = '0;
    out_inst       = '0;
    unique case (state_q)
      S_FETCH: begin
        out_mem_req = 1'b1;
        if (in_clear_all) state_d = in_mem_ready ? S_DROP : S_NEXT;
        else if (in_mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_mem_valid) begin
          if (in_clear_all) begin
            state_d = S_NEXT;
          end else begin
            buf_d   = in_mem_data;
            state_d = S_DISPATCH;
          end
        end else if (in_clear_all) begin
          state_d = S_DROP;
        end
      end
      S_DISPATCH: begin
        out_last_pc   = fetch_q;
        out_inst_pc   = fetch_q;
        out_last_inst = buf_q;
        out_inst      = buf_q;
        if (in_clear_all) begin
          state_d = S_NEXT;
        end else if (!in_queue_full) begin
          out_inst_valid = 1'b1;
          out_pc_ena     = 1'b1;
          state_d        = S_NEXT;
        end
      end
      S_NEXT: begin
        // Staying here on a flush lets the PC unit's corrected pc arrive next cycle.
        fetch_d = in_next_pc;
        if (!in_clear_all) state_d = S_FETCH;
      end
      S_DROP: begin
        if (in_mem_valid) state_d = S_NEXT;
      end
      default: state_d = S_FETCH;
    endcase
    if (in_clear_all) out_pc_ena = 1'b1;
    // Reset state is FETCH, but nothing may be requested or enabled while held in reset.
    if (!rst) begin
      out_mem_req = 1'b0;
      out_pc_ena  = 1'b0;
    end
  end

  assign out_mem_addr = fetch_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory and PC-unit models, directed scenarios, randomized
// traffic, and an expected-queue scoreboard fed at request acceptance.
module tb_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0;

  logic        clk, rst;
  logic        out_pc_ena, in_clear_all, out_mem_req, in_mem_ready, in_mem_valid;
  logic        out_inst_valid, in_queue_full;
  logic [31:0] out_last_pc, out_last_inst, in_next_pc, out_mem_addr, in_mem_data;
  logic [31:0] out_inst, out_inst_pc;
  logic [2:0]  dbg_state;

  fetch_ctrl #(.ADDR_WIDTH(32), .INST_WIDTH(32), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst(rst),
    .out_pc_ena(out_pc_ena), .out_last_pc(out_last_pc), .out_last_inst(out_last_inst),
    .in_next_pc(in_next_pc), .in_clear_all(in_clear_all),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_ready(in_mem_ready), .in_mem_valid(in_mem_valid), .in_mem_data(in_mem_data),
    .out_inst_valid(out_inst_valid), .out_inst(out_inst), .out_inst_pc(out_inst_pc),
    .in_queue_full(in_queue_full), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] acc_log[$];
  int          push_cyc[$];
  logic [31:0] exp_fetch = BOOT;
  logic [31:0] corr_addr = 32'h0;

  bit mem_rand_ready = 0;
  int mem_ready_stall = 0;
  int lat_lo = 0;
  int lat_hi = 0;

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit (got running, required finished)");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- reference functions ----------------
  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return enc_jal(21'h20);
    if (a[5:2] == 4'hE) return enc_jal(21'h40);
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] imm;
    if (inst[6:0] == 7'b1101111) begin
      imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      return pc + imm;
    end
    return pc + 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory controller model ----------------
  initial begin : mem_model
    bit          pending;
    int          lat;
    logic [31:0] pend_addr;
    pending = 0; lat = 0; pend_addr = '0;
    in_mem_ready = 1'b0; in_mem_valid = 1'b0; in_mem_data = '0;
    forever begin
      @(negedge clk);
      in_mem_valid = 1'b0;
      if (!rst) begin
        pending = 0;
        in_mem_ready = 1'b0;
      end else begin
        if (pending) begin
          if (lat == 0) begin
            in_mem_valid = 1'b1;
            in_mem_data  = mem_word(pend_addr);
            pending      = 0;
          end else begin
            lat--;
          end
        end
        if (mem_rand_ready) begin
          in_mem_ready = ($urandom_range(0, 2) != 0);
        end else if (mem_ready_stall > 0) begin
          in_mem_ready = 1'b0;
          if (out_mem_req) mem_ready_stall--;
        end else begin
          in_mem_ready = 1'b1;
        end
        #1;
        if (out_mem_req && in_mem_ready) begin
          pending   = 1;
          pend_addr = out_mem_addr;
          lat       = $urandom_range(lat_lo, lat_hi);
        end
      end
    end
  end

  // ---------------- PC unit model (registered next pc) ----------------
  initial begin : pc_model
    logic [31:0] nxt;
    bit          upd;
    in_next_pc = BOOT;
    forever begin
      @(negedge clk);
      #1;
      upd = rst && out_pc_ena;
      nxt = in_clear_all ? corr_addr : predict(out_last_pc, out_last_inst);
      @(posedge clk);
      #1;
      if (!rst) in_next_pc = BOOT;
      else if (upd) in_next_pc = nxt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          prev_hold, prev_push;
    logic [31:0] prev_addr, e_pc, e_inst;
    int          idle;
    prev_hold = 0; prev_push = 0; prev_addr = '0; idle = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst) begin
        exp_q.delete();
        exp_inst_q.delete();
        exp_fetch = BOOT;
        prev_hold = 0; prev_push = 0; idle = 0;
      end else begin
        if (prev_hold) begin
          chk1("req_hold", out_mem_req, 1'b1);
          chk("addr_hold", out_mem_addr, prev_addr);
        end
        if (prev_push) chk1("push_gap", out_inst_valid, 1'b0);
        chk1("pc_ena", out_pc_ena, out_inst_valid || in_clear_all);
        if (in_clear_all || in_queue_full) chk1("push_blocked", out_inst_valid, 1'b0);
        if (out_inst_valid) begin
          push_cnt++;
          push_cyc.push_back(cyc);
          idle = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_push: got pc %h with nothing outstanding, required no push", out_inst_pc);
          end else begin
            e_pc   = exp_q.pop_front();
            e_inst = exp_inst_q.pop_front();
            chk("push_pc", out_inst_pc, e_pc);
            chk("push_inst", out_inst, e_inst);
            chk("ena_pc", out_last_pc, e_pc);
            chk("ena_inst", out_last_inst, e_inst);
          end
        end
        if (out_mem_req && in_mem_ready) begin
          chk("fetch_addr", out_mem_addr, exp_fetch);
          acc_log.push_back(out_mem_addr);
          exp_q.push_back(exp_fetch);
          exp_inst_q.push_back(mem_word(exp_fetch));
          exp_fetch = predict(exp_fetch, mem_word(exp_fetch));
          idle = 0;
        end
        // A flush kills every fetch not yet pushed; fetching resumes at the corrected pc.
        if (in_clear_all) begin
          exp_q.delete();
          exp_inst_q.delete();
          exp_fetch = corr_addr;
          idle = 0;
        end
        idle++;
        if (idle > 80) begin
          n_checks++; n_fail++;
          $display("FAIL watchdog: got %0d idle cycles, required at most 80", idle);
          idle = 0;
        end
        prev_hold = out_mem_req && !in_mem_ready && !in_clear_all;
        prev_addr = out_mem_addr;
        prev_push = out_inst_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (rst && out_mem_req && in_mem_ready) ok = 1;
    end
    chk1("wait_accept", ok, 1'b1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (in_mem_valid) ok = 1;
    end
    chk1("wait_valid", ok, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [31:0] boot_seq [6];
    int          p0;
    boot_seq[0] = 32'h0;  boot_seq[1] = 32'h4;  boot_seq[2] = 32'h8;
    boot_seq[3] = 32'hC;  boot_seq[4] = 32'h10; boot_seq[5] = 32'h30;
    rst = 1'b0; in_clear_all = 1'b0; in_queue_full = 1'b0;

    // reset values
    idle_cycles(2);
    #3;
    chk1("rst_req", out_mem_req, 1'b0);
    chk("rst_addr", out_mem_addr, BOOT);
    chk1("rst_ena", out_pc_ena, 1'b0);
    chk1("rst_valid", out_inst_valid, 1'b0);
    chk("rst_last_pc", out_last_pc, 32'h0);
    chk("rst_last_inst", out_last_inst, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_inst_pc", out_inst_pc, 32'h0);

    // zero-wait boot sequence, including the jal at 0x10
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk1("first_req", out_mem_req, 1'b1);
    for (int i = 0; i < 60 && acc_log.size() < 7; i++) @(negedge clk);
    for (int i = 0; i < 6; i++) chk("boot_seq", (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF, boot_seq[i]);
    for (int i = 1; i < 5; i++)
      chk("spacing", (push_cyc.size() > i) ? 32'(push_cyc[i] - push_cyc[i-1]) : 32'hFFFF, 32'd4);

    // queue full for 5 cycles in DISPATCH
    wait_valid();
    p0 = push_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_queue_full = 1'b1;
      #3;
      chk1("stall_push", out_inst_valid, 1'b0);
      chk1("stall_ena", out_pc_ena, 1'b0);
    end
    @(negedge clk);
    in_queue_full = 1'b0;
    #3;
    chk1("stall_release", out_inst_valid, 1'b1);
    chk("stall_count", 32'(push_cnt - p0), 32'd1);

    // slow memory: ready low 3 cycles, response 4 cycles after acceptance
    mem_ready_stall = 3; lat_lo = 3; lat_hi = 3;
    wait_accept();
    p0 = push_cnt;
    wait_accept();
    chk("busy_single_push", 32'(push_cnt - p0), 32'd1);

    // flush in WAIT, response arrives 2 cycles later and must be discarded
    lat_lo = 2; lat_hi = 2;
    wait_accept();
    @(negedge clk);
    in_clear_all = 1'b1; corr_addr = 32'h100;
    #3;
    chk1("clr_wait_ena", out_pc_ena, 1'b1);
    chk1("clr_wait_push", out_inst_valid, 1'b0);
    @(negedge clk);
    in_clear_all = 1'b0;
    p0 = push_cnt;
    wait_accept();
    chk("clr_wait_refetch", acc_log[$], 32'h100);
    chk("clr_wait_nopush", 32'(push_cnt - p0), 32'd0);

    // flush in DISPATCH with the queue not full
    lat_lo = 0; lat_hi = 0;
    wait_valid();
    @(negedge clk);
    in_clear_all = 1'b1; corr_addr = 32'h200;
    #3;
    chk1("clr_disp_push", out_inst_valid, 1'b0);
    chk1("clr_disp_ena", out_pc_ena, 1'b1);
    @(negedge clk);
    in_clear_all = 1'b0;
    wait_accept();
    chk("clr_disp_refetch", acc_log[$], 32'h200);

    // asynchronous reset in WAIT
    lat_lo = 4; lat_hi = 4;
    wait_accept();
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk1("arst_req", out_mem_req, 1'b0);
    chk("arst_addr", out_mem_addr, BOOT);
    chk1("arst_ena", out_pc_ena, 1'b0);
    chk1("arst_valid", out_inst_valid, 1'b0);
    idle_cycles(2);
    @(negedge clk);
    rst = 1'b1;
    wait_accept();
    chk("arst_refetch", acc_log[$], BOOT);

    // randomized traffic
    p0 = push_cnt;
    mem_rand_ready = 1; lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_queue_full = ($urandom_range(0, 3) == 0);
      in_clear_all  = ($urandom_range(0, 11) == 0);
      if (in_clear_all) corr_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    end
    @(negedge clk);
    in_queue_full = 1'b0; in_clear_all = 1'b0;
    idle_cycles(20);
    n_checks++;
    if (push_cnt - p0 < 50) begin
      n_fail++;
      $display("FAIL progress: got %0d random-phase pushes, required at least 50", push_cnt - p0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that drives the branch-predicting PC unit. Issues one instruction read at a time to the memory controller and hands each returned word plus its address to the instruction queue. Pulses the PC unit's enable with the just-fetched pc/instruction, then fetches from the predicted next pc. Handles misbranch flushes, including discarding a memory response that is already in flight.

## Interface
- ADDR_WIDTH, 32, fetch address width
- INST_WIDTH, 32, instruction width
- BOOT_ADDR, 32'h0, first fetch address after reset
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- out_pc_ena  output  1  one-cycle enable to PC unit
- out_last_pc  output  ADDR_WIDTH  pc of instruction given to PC unit
- out_last_inst  output  INST_WIDTH  instruction given to PC unit
- in_next_pc  input  ADDR_WIDTH  registered predicted/corrected next pc from PC unit
- in_clear_all  input  1  misbranch flush, combinational from PC unit
- out_mem_req  output  1  fetch request, held until accepted
- out_mem_addr  output  ADDR_WIDTH  fetch address
- in_mem_ready  input  1  request accepted when req && ready
- in_mem_valid  input  1  one-cycle response strobe
- in_mem_data  input  INST_WIDTH  response word
- out_inst_valid  output  1  one-cycle push to instruction queue
- out_inst  output  INST_WIDTH  pushed instruction
- out_inst_pc  output  ADDR_WIDTH  pc of pushed instruction
- in_queue_full  input  1  queue cannot accept a push this cycle

## Operation
- States: FETCH, WAIT, DISPATCH, NEXT, DROP. Registers: fetch_addr, inst_buf, drop flag implied by DROP.
- FETCH: out_mem_req=1, out_mem_addr=fetch_addr. On req&&ready go WAIT.
- WAIT: on in_mem_valid latch in_mem_data into inst_buf, go DISPATCH.
- DISPATCH: if !in_queue_full, assert out_inst_valid, out_pc_ena, out_last_pc=out_inst_pc=fetch_addr, out_last_inst=out_inst=inst_buf, go NEXT. Otherwise hold; outputs stable.
- NEXT: latch fetch_addr<=in_next_pc, go FETCH.
- Misbranch (in_clear_all=1) overrides everything in that cycle. Assert out_pc_ena (PC unit captures the corrected address); suppress out_inst_valid. Then:
  - FETCH, not accepted: drop req, go NEXT.
  - FETCH accepted same cycle, or WAIT without valid: go DROP.
  - WAIT with valid same cycle: discard data, go NEXT.
  - DISPATCH: no push, go NEXT.
  - NEXT: stay NEXT.
  - DROP: stay DROP.
- DROP: out_mem_req=0; on in_mem_valid discard data, go NEXT.
- Only one outstanding memory request ever; requests are never cancelled after acceptance.
- Address arithmetic belongs to the PC unit; this block never adds to pc.

## Timing
- Reset (rst=0, async): state=FETCH, fetch_addr=BOOT_ADDR, inst_buf=0, all outputs 0 except out_mem_addr=BOOT_ADDR. First request asserted on the first cycle after rst deasserts.
- Reset mid-operation: immediate return to reset state. An in-flight memory response after reset is not this block's concern; the memory controller shares the reset.
- out_pc_ena, out_inst_valid: single-cycle pulses, never two consecutive from DISPATCH.
- Throughput with zero-wait memory (ready in FETCH, valid the next cycle): 4 cycles per instruction (FETCH, WAIT, DISPATCH, NEXT).
- in_next_pc is sampled only in NEXT, exactly one cycle after an out_pc_ena pulse.
- out_mem_addr and out_mem_req are stable while req=1 and ready=0.

## Test plan
- Reset with BOOT_ADDR=0, zero-wait memory returning addi words -> requests at 0x0, 0x4, 0x8; each push carries the matching pc; one out_pc_ena per push; 4-cycle spacing.
- Word at 0x10 is a jal, +0x20; PC unit model returns 0x30 -> next out_mem_addr=0x30.
- in_queue_full held for 5 cycles in DISPATCH -> no push or ena during the stall; push on the first cycle after full drops; data unchanged.
- in_mem_ready low 3 cycles, then in_mem_valid 4 cycles after acceptance -> req and addr held stable; single push.
- in_clear_all pulsed in WAIT, corrected address 0x100, response arrives 2 cycles later -> ena pulse in the clear cycle; response discarded, no push; next request at 0x100.
- in_clear_all in DISPATCH with the queue not full -> no push, ena asserted, next fetch at the corrected address.
- rst asserted mid-WAIT -> outputs clear asynchronously; the fetch restarts at BOOT_ADDR.
